// File: rtl/dbram_stream_reader.sv
// dbram_stream_reader
// Read-side controller for a two-bank ping-pong RAM. The writer fills one
// bank while this block drains the other. It generates read addresses, absorbs
// the RAM's one-cycle read latency through a 2-entry output FIFO, and hands
// each bank back to the writer with a bank_free pulse once its last word has
// been fetched.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   bank_full, bank_len   writer handoff pulse and word count of that bank
//   bank_free             pulse: current read bank fully fetched
//   full_count            banks filled and not yet freed (0..2)
//   rd_bank, rd_addr      RAM read bank / address
//   rd_en, rd_data        read strobe; data returns the following cycle
//   out_data, out_valid,
//   out_ready, out_last   output stream, out_last on the final word of a bank
//   err_overflow          sticky: bank_full arrived with both banks full
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no bank in progress; load the length of rd_bank when one is full
// READ  | issuing reads while FIFO + in-flight leaves room
// WAIT  | last read issued; waiting for its data to land in the FIFO
module dbram_stream_reader #(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096,
    parameter int DWIDTH    = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank_full,
    input  logic [AWIDTH:0]   bank_len,
    output logic              bank_free,
    output logic [1:0]        full_count,
    output logic              rd_bank,
    output logic [AWIDTH-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err_overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [AWIDTH:0] LEN_MAX = (AWIDTH+1)'(NUM_WORDS);
    localparam logic [AWIDTH:0] LEN_ONE = (AWIDTH+1)'(1);

    logic [1:0]        state;
    logic              wr_ptr;
    logic [AWIDTH:0]   len_store [2];
    logic [AWIDTH:0]   len_in;
    logic [AWIDTH:0]   remaining;
    logic              rd_pend;
    logic              pend_last;

    logic [DWIDTH-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              fifo_wp;
    logic              fifo_rp;
    logic [1:0]        fifo_cnt;

    logic              push;
    logic              pop;
    logic [2:0]        occupancy;
    logic              credit_ok;
    logic              accept_full;

    // Over-range lengths are clamped to a full bank rather than running past it.
    assign len_in = (bank_len > LEN_MAX) ? LEN_MAX : bank_len;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = rd_pend;
    assign out_data  = fifo_data[fifo_rp];
    assign out_last  = out_valid & fifo_last[fifo_rp];

    // A same-cycle pop frees a slot, which is what allows one word per cycle.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, rd_pend};
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});
    assign rd_en     = (state == ST_READ) && credit_ok;

    // pend_last is only ever set by the final issue, which also moved us to WAIT.
    assign bank_free   = (state == ST_WAIT) && rd_pend && pend_last;
    assign accept_full = bank_full && ((full_count != 2'd2) || bank_free);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= 1'b0;
            len_store[0] <= '0;
            len_store[1] <= '0;
            full_count   <= 2'd0;
            rd_bank      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (accept_full) begin
                len_store[wr_ptr] <= len_in;
                wr_ptr            <= ~wr_ptr;
            end else if (bank_full) begin
                err_overflow <= 1'b1;
            end
            case ({accept_full, bank_free})
                2'b10:   full_count <= full_count + 2'd1;
                2'b01:   full_count <= full_count - 2'd1;
                default: full_count <= full_count;
            endcase
            if (bank_free) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            rd_addr   <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            rd_pend   <= rd_en;
            pend_last <= rd_en && (remaining == LEN_ONE);
            case (state)
                ST_IDLE: begin
                    // With no bank queued, rd_bank equals the write pointer, so a
                    // bank arriving now is ours; bypass the store to save a cycle.
                    if (full_count != 2'd0) begin
                        remaining <= len_store[rd_bank];
                        rd_addr   <= '0;
                        state     <= ST_READ;
                    end else if (accept_full) begin
                        remaining <= len_in;
                        rd_addr   <= '0;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        rd_addr   <= rd_addr + AWIDTH'(1);
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bank_free) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= 2'b00;
            fifo_wp      <= 1'b0;
            fifo_rp      <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[fifo_wp] <= rd_data;
                fifo_last[fifo_wp] <= pend_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dbram_stream_reader.sv
// Testbench for dbram_stream_reader: RAM model, output-stream monitor with an
// independent FIFO occupancy model, table-driven single-bank runs with varied
// backpressure, and hand-written multi-cycle sequences.
module tb_dbram_stream_reader;

    localparam int AW = 12;
    localparam int NW = 4096;
    localparam int DW = 60;

    logic          clk;
    logic          reset;
    logic          bank_full;
    logic [AW:0]   bank_len;
    logic          bank_free;
    logic [1:0]    full_count;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          err_overflow;

    dbram_stream_reader #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .bank_full(bank_full), .bank_len(bank_len),
        .bank_free(bank_free), .full_count(full_count), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err_overflow(err_overflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } word_t;

    typedef struct {
        int           len;
        logic [15:0]  mask;
        logic         bank;
        logic         bank_after;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          free_cnt = 0;
    int          occ_m    = 0;
    int          infl_m   = 0;
    int          last_addr = 0;
    word_t       log_q[$];
    logic        stalled_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic        prev_last;
    logic        use_mask = 1'b0;
    logic [15:0] ready_mask = 16'hFFFF;
    logic [3:0]  ph = 4'd0;
    vec_t        rows[6];

    function automatic logic [DW-1:0] ram_word(input logic b, input logic [AW-1:0] a);
        logic [35:0] lo;
        lo = 36'(a) * 36'd3 + 36'(b);
        return {b, 11'h5A5, a, lo};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data for the address strobed this cycle appears next cycle.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram_word(rd_bank, rd_addr);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (use_mask) begin
                out_ready = ready_mask[ph];
                ph = ph + 4'd1;
            end
        end
    end

    // Stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        int pop;
        if (reset) begin
            occ_m = 0;
            infl_m = 0;
            stalled_prev = 1'b0;
        end else begin
            pop = (out_valid && out_ready) ? 1 : 0;
            chk("valid_vs_model", 64'(out_valid), 64'(occ_m != 0));
            if (rd_en) begin
                chk("credit", 64'((occ_m + infl_m - pop) < 2), 64'd1);
                last_addr = int'(rd_addr);
            end
            if (stalled_prev)
                chk("stall_hold", 64'({out_valid, out_last, out_data}),
                    64'({1'b1, prev_last, prev_data}));
            if (pop == 1) log_q.push_back('{out_data, out_last, cyc});
            if (bank_free) free_cnt++;
            occ_m = occ_m + infl_m - pop;
            infl_m = rd_en ? 1 : 0;
            stalled_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bank_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        log_q.delete();
        free_cnt = 0;
    endtask

    task automatic pulse_full(input int len);
        bank_full = 1'b1;
        bank_len = (AW+1)'(len);
        @(posedge clk);
        #1;
        bank_full = 1'b0;
    endtask

    task automatic wait_words(input string nm, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(nm, 64'(log_q.size() >= n), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string nm, input int base, input int len, input logic bank);
        int bad = 0;
        if (log_q.size() < base + len) bad = len;
        else
            for (int i = 0; i < len; i++)
                if (log_q[base+i].data !== ram_word(bank, AW'(i)) ||
                    log_q[base+i].last !== (i == len - 1)) bad++;
        chk(nm, 64'(bad), 64'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, 64'({full_count, rd_bank, rd_addr, rd_en, bank_free, out_valid,
                     out_last, err_overflow}), 64'd0);
        chk({nm, "_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        int t0;
        int base;
        int free0;

        rows[0] = '{6, 16'h9999, 1'b0, 1'b1};
        rows[1] = '{1, 16'hFFFF, 1'b1, 1'b0};
        rows[2] = '{5, 16'hAAAA, 1'b0, 1'b1};
        rows[3] = '{3, 16'h0303, 1'b1, 1'b0};
        rows[4] = '{7, 16'h8421, 1'b0, 1'b1};
        rows[5] = '{2, 16'hFFFF, 1'b1, 1'b0};

        reset = 1'b1;
        bank_full = 1'b0;
        bank_len = '0;
        out_ready = 1'b1;

        // Reset state and first-bank latency.
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        t0 = cyc;
        pulse_full(4);
        @(negedge clk);
        chk("t1_fc_cycle1", 64'(full_count), 64'd1);
        chk("t1_rden_cycle1", 64'({rd_en, rd_addr}), 64'({1'b1, 12'd0}));
        wait_words("t1_timeout", 4, 20);
        chk("t1_first_cycle", 64'(log_q[0].cyc), 64'(t0 + 3));
        chk("t1_last_cycle", 64'(log_q[3].cyc), 64'(t0 + 6));
        check_bank("t1_words", 0, 4, 1'b0);
        idle(3);
        chk("t1_free", 64'(free_cnt), 64'd1);
        chk("t1_end", 64'({full_count, rd_bank, out_valid}), 64'({2'd0, 1'b1, 1'b0}));

        // Back-to-back banks.
        do_reset();
        pulse_full(3);
        pulse_full(5);
        @(negedge clk);
        chk("t2_fc2", 64'(full_count), 64'd2);
        wait_words("t2_timeout", 8, 60);
        check_bank("t2_bank0", 0, 3, 1'b0);
        check_bank("t2_bank1", 3, 5, 1'b1);
        idle(3);
        chk("t2_free", 64'(free_cnt), 64'd2);
        chk("t2_err", 64'(err_overflow), 64'd0);
        chk("t2_count", 64'(log_q.size()), 64'd8);

        // Overflow: third bank while both are held.
        do_reset();
        out_ready = 1'b0;
        pulse_full(4);
        pulse_full(3);
        pulse_full(7);
        @(negedge clk);
        chk("t3_err", 64'(err_overflow), 64'd1);
        chk("t3_fc", 64'(full_count), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_words("t3_timeout", 7, 60);
        idle(20);
        chk("t3_count", 64'(log_q.size()), 64'd7);
        check_bank("t3_bank0", 0, 4, 1'b0);
        check_bank("t3_bank1", 4, 3, 1'b1);
        chk("t3_end", 64'({full_count, err_overflow}), 64'({2'd0, 1'b1}));
        chk("t3_free", 64'(free_cnt), 64'd2);

        // Table-driven banks under varied backpressure.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            base = log_q.size();
            free0 = free_cnt;
            ready_mask = rows[r].mask;
            ph = 4'd0;
            use_mask = 1'b1;
            pulse_full(rows[r].len);
            wait_words($sformatf("row%0d_timeout", r), base + rows[r].len, 200);
            idle(6);
            chk($sformatf("row%0d_count", r), 64'(log_q.size()), 64'(base + rows[r].len));
            check_bank($sformatf("row%0d_words", r), base, rows[r].len, rows[r].bank);
            chk($sformatf("row%0d_free", r), 64'(free_cnt - free0), 64'd1);
            chk($sformatf("row%0d_end", r), 64'({full_count, rd_bank}),
                64'({2'd0, rows[r].bank_after}));
        end
        use_mask = 1'b0;
        out_ready = 1'b1;

        // Full-size bank at full rate.
        do_reset();
        pulse_full(NW);
        wait_words("t5_timeout", NW, NW + 100);
        check_bank("t5_words", 0, NW, 1'b0);
        if (log_q.size() >= NW)
            chk("t5_rate", 64'(log_q[NW-1].cyc - log_q[0].cyc), 64'(NW - 1));
        chk("t5_last_addr", 64'(last_addr), 64'(NW - 1));
        idle(3);
        chk("t5_end", 64'({full_count, rd_bank}), 64'({2'd0, 1'b1}));

        // Reset in the middle of a bank.
        do_reset();
        pulse_full(8);
        wait_words("t6_timeout", 2, 20);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async_reset");
        idle(2);
        reset = 1'b0;
        log_q.delete();
        free_cnt = 0;
        pulse_full(2);
        wait_words("t6_timeout2", 2, 20);
        idle(20);
        chk("t6_count", 64'(log_q.size()), 64'd2);
        check_bank("t6_words", 0, 2, 1'b0);
        chk("t6_free", 64'(free_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
